// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the operand/accumulator datapath sequencer.
// Holds the state encoding, ALU op codes and the CE bit-position and width helpers.
package dp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [2:0] OP_PASS = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b011;

    // CE layout: operand registers in [nsrc-1:0], then the output register, then the accumulator.
    function automatic int ce_out_idx(input int nsrc);
        return nsrc;
    endfunction

    function automatic int ce_acc_idx(input int nsrc);
        return nsrc + 1;
    endfunction

    function automatic int sel_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

    function automatic int ctr_width(input int nsrc, input int wr_cyc);
        int m;
        m = (nsrc > wr_cyc) ? nsrc : wr_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dp_sequencer_param_if.sv
// Handshake and control bundle between the sequencer and whoever drives it.
// The slave modport is the sequencer's view; the master modport is the requester's view.
interface dp_sequencer_param_if
    import dp_seq_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int AW   = 3,
    parameter int WW   = 3
);
    localparam int SW = sel_width(NSRC);

    logic                 start;
    logic                 hold;
    logic                 cont;
    logic [NSRC*AW-1:0]   ops;
    logic                 clr;
    logic [WW-1:0]        w;
    logic [NSRC+1:0]      ce;
    logic [SW-1:0]        sel;
    logic [AW-1:0]        s;
    logic                 busy;
    logic                 done;

    modport master (output start, hold, cont, ops,
                    input  clr, w, ce, sel, s, busy, done);

    modport slave  (input  start, hold, cont, ops,
                    output clr, w, ce, sel, s, busy, done);

endinterface

// File: rtl/dp_seq_step_ctr.sv
// Step counter shared by the fold (EXEC) and write-out (WRITE) phases.
// It wraps to zero when it reaches the runtime limit, so each phase begins at step 0.
module dp_seq_step_ctr #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          hold_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] cnt_o,
    output logic          term_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == limit_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hold_i) begin
            cnt_d = term_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dp_sequencer_param.sv
// Control sequencer: clear, load NSRC operands, fold them one per cycle, then write out.
// All outputs are decoded from registers; a stalled cycle repeats its state with the enables masked.
module dp_sequencer_param
    import dp_seq_pkg::*;
#(
    parameter int            NSRC    = 2,
    parameter int            AW      = 3,
    parameter int            WW      = 3,
    parameter logic [WW-1:0] WR_CODE = 3'b100,
    parameter int            WR_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dp_sequencer_param_if.slave  bus
);
    localparam int SW     = sel_width(NSRC);
    localparam int CW     = ctr_width(NSRC, WR_CYC);
    localparam int CE_OUT = ce_out_idx(NSRC);
    localparam int CE_ACC = ce_acc_idx(NSRC);

    state_e               state_q, state_d;
    logic [NSRC*AW-1:0]   ops_q, ops_d;
    logic                 stall_q, stall_d;
    logic [CW-1:0]        step;
    logic [CW-1:0]        limit;
    logic                 term;
    logic                 ctr_clr;
    logic                 ctr_en;
    logic [AW-1:0]        op_cur;

    logic                 clr_o;
    logic [WW-1:0]        w_o;
    logic [NSRC+1:0]      ce_o;
    logic [SW-1:0]        sel_o;
    logic [AW-1:0]        s_o;
    logic                 busy_o;
    logic                 done_o;

    assign ctr_en  = (state_q == ST_EXEC) || (state_q == ST_WRITE);
    assign ctr_clr = !ctr_en;
    assign limit   = (state_q == ST_EXEC) ? CW'(NSRC - 1) : CW'(WR_CYC - 1);

    dp_seq_step_ctr #(.CW(CW)) u_step_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ctr_clr),
        .en_i    (ctr_en),
        .hold_i  (bus.hold),
        .limit_i (limit),
        .cnt_o   (step),
        .term_o  (term)
    );

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        stall_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLEAR;
                    ops_d   = bus.ops;
                end
            end
            ST_CLEAR: begin
                if (bus.hold) stall_d = 1'b1;
                else          state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.hold) stall_d = 1'b1;
                else          state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.hold)  stall_d = 1'b1;
                else if (term) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.hold)  stall_d = 1'b1;
                else if (term) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.cont) begin
                    state_d = ST_CLEAR;
                    ops_d   = bus.ops;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ops_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        op_cur = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (step == CW'(k)) op_cur = ops_q[k*AW +: AW];
        end
    end

    // The enables are masked on a repeated (stalled) cycle so no register is loaded twice.
    always_comb begin
        clr_o  = 1'b0;
        w_o    = '0;
        ce_o   = '0;
        sel_o  = '0;
        s_o    = '0;
        busy_o = 1'b1;
        done_o = 1'b0;
        unique case (state_q)
            ST_IDLE:  busy_o = 1'b0;
            ST_CLEAR: clr_o = !stall_q;
            ST_LOAD:  ce_o[NSRC-1:0] = {NSRC{!stall_q}};
            ST_EXEC: begin
                ce_o[CE_ACC] = !stall_q;
                sel_o        = step[SW-1:0];
                s_o          = op_cur;
            end
            ST_WRITE: begin
                w_o          = WR_CODE;
                ce_o[CE_OUT] = !stall_q;
            end
            ST_DONE:  done_o = 1'b1;
            default:  busy_o = 1'b0;
        endcase
    end

    assign bus.clr  = clr_o;
    assign bus.w    = w_o;
    assign bus.ce   = ce_o;
    assign bus.sel  = sel_o;
    assign bus.s    = s_o;
    assign bus.busy = busy_o;
    assign bus.done = done_o;

endmodule
